// File: rtl/music_box_pkg.sv
// music_box_pkg: shared types and constants for the music box audio path.
package music_box_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, WAIT_ZERO, GAP} note_seq_state_t;
  typedef struct packed {
    logic [13:0] freq;
    logic [7:0]  amp;
    logic [7:0]  dur;
  } note_word_t;
  localparam int FS_HZ = 32000;
  localparam int DEFAULT_TICK_DIV = FS_HZ / 1000;
endpackage

// File: rtl/ms_tick_gen.sv
// ms_tick_gen: counts TICK_DIV enabled cycles and emits a one-cycle tick; clr restarts the count.
module ms_tick_gen #(
  parameter int TICK_DIV = 32
)(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick = en && cnt_q == LAST;
  always_comb cnt_d = (clr || tick) ? '0 : en ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: plays a note ROM through one tone generator with an articulation gap per note.
// Define NOTE_SEQ_ZERO_SYNC_EN to hold each note until the generator reports a phase-zero crossing.
module note_sequencer
  import music_box_pkg::*;
#(
  parameter int NOTE_COUNT = 32,
  parameter int TICK_DIV   = DEFAULT_TICK_DIV,
  parameter int GAP_CYCLES = 32,
  parameter int ZS_TIMEOUT = 320
)(
  input  logic                          CLK_32KHz,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          loop_en,
  output logic [$clog2(NOTE_COUNT)-1:0] rom_addr,
  input  logic [29:0]                   rom_data,
  input  logic                          indexZero,
  output logic [13:0]                   outputFrequency,
  output logic [7:0]                    outputAmplitude,
  output logic                          note_strobe,
  output logic                          busy,
  output logic                          done
);
  localparam int AW = $clog2(NOTE_COUNT);
  localparam int CW = $clog2((ZS_TIMEOUT > GAP_CYCLES ? ZS_TIMEOUT : GAP_CYCLES) + 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(NOTE_COUNT - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  note_seq_state_t state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [13:0] freq_q, freq_d;
  logic [7:0] amp_q, amp_d, units_q, units_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic strobe_q, strobe_d, busy_q, busy_d, done_q, done_d, tick, end_song;
  note_word_t word;
  assign word = note_word_t'(rom_data);
`ifdef NOTE_SEQ_ZERO_SYNC_EN
  localparam logic [CW-1:0] ZS_LAST = CW'(ZS_TIMEOUT - 1);
`else
  logic unused_index_zero;
  assign unused_index_zero = indexZero;
`endif
  ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk(CLK_32KHz), .rst_n(reset_n), .en(state_q == PLAY), .clr(state_q != PLAY), .tick(tick)
  );
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    freq_d = freq_q;
    amp_d = amp_q;
    units_d = units_q;
    cnt_d = '0;
    strobe_d = 1'b0;
    done_d = 1'b0;
    end_song = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = FETCH;
        addr_d = '0;
      end
      FETCH: state_d = LOAD;
      LOAD: if (word.dur == 8'd0) end_song = 1'b1;
      else begin
        freq_d = word.freq;
        amp_d = word.freq == 14'd0 ? 8'd0 : word.amp;
        units_d = word.dur;
        strobe_d = 1'b1;
        state_d = PLAY;
      end
      PLAY: if (tick) begin
        units_d = units_q - 8'd1;
        if (units_q == 8'd1) begin
`ifdef NOTE_SEQ_ZERO_SYNC_EN
          state_d = WAIT_ZERO;
`else
          state_d = GAP;
          amp_d = '0;
`endif
        end
      end
`ifdef NOTE_SEQ_ZERO_SYNC_EN
      WAIT_ZERO: if (indexZero || cnt_q == ZS_LAST) begin
        state_d = GAP;
        amp_d = '0;
      end else cnt_d = cnt_q + CW'(1);
`endif
      GAP: if (cnt_q != GAP_LAST) cnt_d = cnt_q + CW'(1);
      else if (addr_q == ADDR_LAST) end_song = 1'b1;
      else begin
        addr_d = addr_q + AW'(1);
        state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
    if (end_song) begin
      addr_d = '0;
      state_d = loop_en ? FETCH : IDLE;
      done_d = !loop_en;
    end
    // stop overrides everything, including a same-cycle start or song end
    if (stop || state_d == IDLE) begin
      state_d = IDLE;
      addr_d = '0;
      freq_d = '0;
      amp_d = '0;
      units_d = '0;
      cnt_d = '0;
      strobe_d = 1'b0;
      done_d = done_d & ~stop;
    end
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge CLK_32KHz or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q <= '0;
      freq_q <= '0;
      amp_q <= '0;
      units_q <= '0;
      cnt_q <= '0;
      strobe_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      freq_q <= freq_d;
      amp_q <= amp_d;
      units_q <= units_d;
      cnt_q <= cnt_d;
      strobe_q <= strobe_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  assign rom_addr = addr_q;
  assign outputFrequency = freq_q;
  assign outputAmplitude = amp_q;
  assign note_strobe = strobe_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: directed checks of note_sequencer against hand-computed cycle positions.
module tb_note_sequencer;
`ifdef NOTE_SEQ_ZERO_SYNC_EN
  localparam int ZW = 1;
`else
  localparam int ZW = 0;
`endif
  logic clk = 1'b0, reset_n = 1'b1, start = 1'b0, stop = 1'b0, loop_en = 1'b0, index_zero = 1'b0;
  logic [4:0] rom_addr;
  logic [29:0] rom_data = '0;
  logic [29:0] rom [32];
  logic [13:0] freq;
  logic [7:0] amp;
  logic note_strobe, busy, done;
  int n_tests = 0, n_fail = 0;
  int first_strobe_k, strobe_cnt, last_strobe_k, prev_strobe_k, amp_hi_cnt, first_gap_k, addr1_k, done_cnt, done_k;
  int iz_k = 0;
  logic [13:0] strobe_freq;
  logic [7:0] strobe_amp;
  logic busy_k0;
  logic [4:0] addr_k0;
  note_sequencer dut (
    .CLK_32KHz(clk), .reset_n(reset_n), .start(start), .stop(stop), .loop_en(loop_en),
    .rom_addr(rom_addr), .rom_data(rom_data), .indexZero(index_zero),
    .outputFrequency(freq), .outputAmplitude(amp), .note_strobe(note_strobe), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];
  function automatic logic [29:0] nw(input int f, input int a, input int d);
    return {f[13:0], a[7:0], d[7:0]};
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic clear_rom();
    foreach (rom[i]) rom[i] = '0;
  endtask
  // pulse start before edge N, then sample after edges N+0 .. N+n-1 (index k)
  task automatic capture(input int n);
    first_strobe_k = -1; last_strobe_k = -1; prev_strobe_k = -1; first_gap_k = -1; addr1_k = -1; done_k = -1;
    strobe_cnt = 0; amp_hi_cnt = 0; done_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 0) begin
        busy_k0 = busy;
        addr_k0 = rom_addr;
      end
      if (note_strobe) begin
        if (first_strobe_k < 0) first_strobe_k = k;
        prev_strobe_k = last_strobe_k;
        last_strobe_k = k;
        strobe_cnt++;
        strobe_freq = freq;
        strobe_amp = amp;
      end
      if (amp != 0) amp_hi_cnt++;
      if (first_gap_k < 0 && first_strobe_k >= 0 && busy && amp == 0 && freq != 0) first_gap_k = k;
      if (addr1_k < 0 && rom_addr == 5'd1) addr1_k = k;
      if (done) begin
        done_cnt++;
        done_k = k;
      end
      index_zero = iz_k >= 0 && k >= iz_k;
    end
  endtask
  initial begin
    int bad;
    clear_rom();
    #1 reset_n = 1'b0;
    #22 reset_n = 1'b1;
    @(negedge clk);
    check("rst_addr", rom_addr, 0);
    check("rst_freq", freq, 0);
    check("rst_amp", amp, 0);
    check("rst_strobe", note_strobe, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rom_addr != 0 || freq != 0 || amp != 0 || note_strobe || busy || done) bad++;
    end
    check("idle_quiet", bad, 0);
    rom[0] = nw(440, 200, 3);
    capture(200);
    check("one_busy_k0", busy_k0, 1);
    check("one_addr_k0", addr_k0, 0);
    check("one_strobe_k", first_strobe_k, 2);
    check("one_freq", strobe_freq, 440);
    check("one_amp", strobe_amp, 200);
    check("one_amp_cycles", amp_hi_cnt, 96 + ZW);
    check("one_gap_k", first_gap_k, 98 + ZW);
    check("one_next_fetch_k", addr1_k, 130 + ZW);
    check("one_done_k", done_k, 132 + ZW);
    check("one_done_cnt", done_cnt, 1);
    check("one_strobe_cnt", strobe_cnt, 1);
    check("one_busy_end", busy, 0);
    check("one_freq_end", freq, 0);
    rom[0] = nw(0, 255, 2);
    capture(150);
    check("rest_strobe_cnt", strobe_cnt, 1);
    check("rest_strobe_k", first_strobe_k, 2);
    check("rest_amp", strobe_amp, 0);
    check("rest_freq", strobe_freq, 0);
    check("rest_amp_cycles", amp_hi_cnt, 0);
    check("rest_done_k", done_k, 100 + ZW);
    for (int i = 0; i < 32; i++) rom[i] = nw(100 + i, 10, 1);
    capture(2200);
    check("full_strobe_cnt", strobe_cnt, 32);
    check("full_last_freq", strobe_freq, 131);
    check("full_period", last_strobe_k - prev_strobe_k, 66 + ZW);
    check("full_done_cnt", done_cnt, 1);
    check("full_done_k", done_k, 2112 + 32 * ZW);
    clear_rom();
    rom[0] = nw(440, 200, 3);
    loop_en = 1'b1;
    capture(410);
    check("loop_done_cnt", done_cnt, 0);
    check("loop_strobe_cnt", strobe_cnt, 4);
    check("loop_period", last_strobe_k - prev_strobe_k, 132 + ZW);
    check("loop_busy", busy, 1);
    check("loop_in_play", amp, 200);
    stop = 1'b1;
    start = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    start = 1'b0;
    check("stop_busy", busy, 0);
    check("stop_amp", amp, 0);
    check("stop_freq", freq, 0);
    check("stop_addr", rom_addr, 0);
    check("stop_done", done, 0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (busy || done || note_strobe) bad++;
    end
    check("stop_stays_idle", bad, 0);
    loop_en = 1'b0;
`ifdef NOTE_SEQ_ZERO_SYNC_EN
    iz_k = 114;
    capture(200);
    check("zs_17_gap_k", first_gap_k, 115);
    check("zs_17_done_k", done_k, 149);
    iz_k = -1;
    capture(500);
    check("zs_timeout_gap_k", first_gap_k, 418);
    check("zs_timeout_done_k", done_k, 452);
    iz_k = 0;
`endif
    capture(20);
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_freq", freq, 0);
    check("arst_amp", amp, 0);
    check("arst_addr", rom_addr, 0);
    @(negedge clk);
    reset_n = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/note_sequencer.md
# note_sequencer

Plays a song stored in an external note ROM by sequencing one tone generator in the music box audio path. Fetches one note word at a time, drives the generator's frequency and amplitude inputs for the note's duration, inserts a silent articulation gap, then advances. Sits between the mode/button control logic and the 32 kHz tone generators; runs entirely in the 32 kHz sample-clock domain.

## Interface
- NOTE_COUNT, 32: ROM depth in notes; address width is clog2(NOTE_COUNT).
- TICK_DIV, 32: clock cycles per duration unit (1 ms at 32 kHz).
- GAP_CYCLES, 32: silent cycles after every note (≥1).
- ZS_TIMEOUT, 320: maximum cycles to wait for a zero crossing (one 100 Hz period).
- CLK_32KHz  input  1  sample clock.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to play from address 0; ignored while busy.
- stop  input  1  one-cycle abort; wins over start in the same cycle.
- loop_en  input  1  on song end, restart at address 0 instead of finishing.
- rom_addr  output  clog2(NOTE_COUNT)  note ROM address.
- rom_data  input  30  note word {freq[29:16], amp[15:8], dur[7:0]}; valid 1 cycle after rom_addr.
- indexZero  input  1  generator phase-zero flag.
- outputFrequency  output  14  frequency to the generator, Hz.
- outputAmplitude  output  8  amplitude to the generator.
- note_strobe  output  1  one-cycle pulse when a new note is applied.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse on non-looping song end.

## Operation
- States: IDLE, FETCH, LOAD, PLAY, WAIT_ZERO, GAP.
- IDLE: all outputs are 0. start moves to FETCH with rom_addr=0.
- FETCH: holds rom_addr for one cycle, then goes to LOAD.
- LOAD: samples rom_data.
  - dur==0 is the end marker. With loop_en, go to FETCH with addr=0. Without it, pulse done and go to IDLE.
  - Otherwise register freq and amp and drive them out. If freq==0 (rest), outputAmplitude=0. Pulse note_strobe and go to PLAY.
- PLAY: lasts exactly dur×TICK_DIV cycles, counted by an 8-bit unit counter plus a tick divider, then goes to WAIT_ZERO.
- WAIT_ZERO: holds the note until indexZero=1 or ZS_TIMEOUT cycles have elapsed, then goes to GAP.
- GAP: drives outputAmplitude=0 and keeps outputFrequency for GAP_CYCLES cycles.
  - If addr<NOTE_COUNT-1, go to FETCH with addr+1.
  - If addr==NOTE_COUNT-1 (wrap), apply the same rule as the end marker.
- stop in any state: next state IDLE, outputs cleared, counters and address cleared, no done pulse.
- reset_n low mid-song: same as stop, asynchronously.

## Timing
- Reset values: rom_addr=0, outputFrequency=0, outputAmplitude=0, note_strobe=0, busy=0, done=0.
- All outputs are registered.
- start at edge N:
  - busy=1 and rom_addr=0 from N+1.
  - LOAD at N+2.
  - outputFrequency/outputAmplitude and note_strobe valid from N+3.
- Per-note period = 2 (FETCH+LOAD) + dur×TICK_DIV + wait + GAP_CYCLES, where wait is 1..ZS_TIMEOUT.
- done pulses in the cycle after LOAD/GAP detects the end; busy falls in that same cycle.
- indexZero is sampled only in WAIT_ZERO. An indexZero=1 on the first WAIT_ZERO cycle exits after 1 cycle.

## Configuration
- NOTE_SEQ_ZERO_SYNC_EN defined: WAIT_ZERO behaves as described, so note releases land on a waveform zero crossing to avoid clicks.
- Macro undefined: WAIT_ZERO is not compiled in. PLAY goes straight to GAP, indexZero is unused, and wait=0 in the period formula.

## Structure
- music_box_pkg holds:
  - the state enum note_seq_state_t;
  - the packed struct note_word_t {freq 14, amp 8, dur 8};
  - the constants DEFAULT_TICK_DIV=32 and FS_HZ=32000.
- One sub-module, ms_tick_gen: a TICK_DIV counter with enable and synchronous clear, producing a one-cycle tick. Used to time PLAY.

## Test plan
- Reset with no start -> all outputs 0 for 100 cycles; done never pulses.
- ROM[0]={440,200,3}, ROM[1]=end; macro off; start -> freq=440, amp=200 for 96 cycles, then amp=0 for 32 cycles, one done pulse, busy low.
- Same ROM with loop_en=1 -> done never pulses; note_strobe pulses every 96+32+4=132 cycles (2 for ROM[0] fetch/load, 2 for the ROM[1] end marker fetch/load).
- Macro on; indexZero first high 17 cycles after PLAY ends -> GAP starts exactly 17 cycles late. With indexZero tied 0 -> GAP starts 320 cycles late.
- stop asserted mid-PLAY, with start in the same cycle -> IDLE next cycle, amp=0, freq=0, rom_addr=0, no done.
- Rest note {0,255,2} -> amp=0 for 64 cycles with note_strobe still pulsed. A ROM with no end marker and loop_en=0 -> done after the NOTE_COUNT-1 entry.
